// File: rtl/banked_dmem_resp.sv
// ---------------------------------------------------------------------------
// banked_dmem_resp
//
// Responder side of the memory-stage data-memory interface. It models a
// four-bank data memory with a fixed latency. One request may be outstanding
// at a time. The request is accepted when `enable` is high and `stall` is low.
// Exactly LATENCY cycles after acceptance, `done` pulses for one cycle. Read
// data is presented on `data_out` in that `done` cycle. A misaligned request
// instead raises `err` together with `done`.
//
// Optional feature macro: BANK_STALL_EN
//   defined   -> each bank has a recovery counter. A request to a busy bank
//                stalls.
//   undefined -> there are no bank counters. Only reset and the in-flight
//                request cause a stall, and BANK_RECOVERY is ignored.
//
// Parameters:
//   LATENCY       cycles from acceptance to done (>= 1)
//   BANK_RECOVERY cycles a bank stays busy after acceptance (>= LATENCY)
//   AW            log2 of the word count (2^AW 16-bit words)
//
// Ports:
//   clk       clock; all state updates on the rising edge
//   rst       synchronous active-high reset
//   enable    request valid
//   wr        1 = write, 0 = read
//   addr      byte address; word = addr[AW:1], bank = addr[2:1]
//   data_in   write data
//   data_out  read data during the done cycle of a read, otherwise 0
//   done      one-cycle completion pulse
//   stall     combinational; the request is not accepted this cycle
//   err       misaligned request, asserted together with done
// ---------------------------------------------------------------------------
module banked_dmem_resp #(
  parameter int LATENCY       = 2,
  parameter int BANK_RECOVERY = 4,
  parameter int AW            = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        done,
  output logic        stall,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int CW = $clog2(LATENCY + 1);
  // WAIT spends LATENCY-1 cycles. The counter therefore starts at LATENCY-2
  // and leaves WAIT when it reaches zero.
  localparam logic [CW-1:0] WAIT_LOAD = CW'((LATENCY > 1) ? LATENCY - 2 : 0);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rd_q, err_q;
  logic [15:0]     rdata_q;
  logic [15:0]     mem [2**AW];

  logic [AW-1:0]   widx;
  logic [1:0]      bank;
  logic            aligned;
  logic            in_flight;
  logic            bank_busy;
  logic            accept;

  assign widx    = addr[AW:1];
  assign bank    = addr[2:1];
  assign aligned = ~addr[0];

  generate
    if (AW < 15) begin : g_unused_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr[15:AW+1];
    end
  endgenerate

  // A request is in flight while the FSM is in WAIT. The RESP cycle is free
  // for a new acceptance.
  assign in_flight = (state_q == S_WAIT);
  assign stall     = enable & (rst | in_flight | bank_busy);
  assign accept    = enable & ~stall;  // stall already covers rst

`ifdef BANK_STALL_EN
  localparam int BW = $clog2(BANK_RECOVERY + 1);
  localparam logic [BW-1:0] BANK_LOAD = BW'(BANK_RECOVERY - 1);

  logic [3:0] busy_vec;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bank
      logic [BW-1:0] bcnt_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          bcnt_q <= '0;
        end else if (accept && aligned && (bank == 2'(gi))) begin
          // Misaligned requests never touch a bank, so they do not load it.
          bcnt_q <= BANK_LOAD;
        end else if (bcnt_q != '0) begin
          bcnt_q <= bcnt_q - 1'b1;
        end
      end
      assign busy_vec[gi] = (bcnt_q != '0);
    end
  endgenerate

  assign bank_busy = busy_vec[bank];
`else
  assign bank_busy = 1'b0;
`endif

  // The array has no reset, so it maps onto block RAM. The write is committed
  // and the read is captured at the acceptance edge.
  always_ff @(posedge clk) begin
    if (accept && aligned) begin
      if (wr) begin
        mem[widx] <= data_in;
      end else begin
        rdata_q <= mem[widx];
      end
    end
  end

  // These flags describe the pending response. They are loaded at
  // acceptance, even in the RESP cycle, because the current response has
  // already been driven by then.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= 1'b0;
      err_q <= 1'b0;
    end else if (accept) begin
      rd_q  <= ~wr & aligned;
      err_q <= ~aligned;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: state_d = S_IDLE;
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Acceptance is only possible in IDLE or RESP, because WAIT always
    // stalls. Acceptance overrides the default transition.
    if (accept) begin
      state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
      cnt_d   = WAIT_LOAD;
    end
  end

  // FSM outputs
  always_comb begin
    done     = 1'b0;
    err      = 1'b0;
    data_out = '0;
    if (state_q == S_RESP) begin
      done     = 1'b1;
      err      = err_q;
      data_out = rd_q ? rdata_q : 16'h0000;
    end
  end

endmodule

// File: tb/tb_banked_dmem_resp.sv
module tb_banked_dmem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        done;
  logic        stall;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

`ifdef BANK_STALL_EN
  localparam int ACC2 = 4;  // same-bank read waits for the bank to recover
`else
  localparam int ACC2 = 2;  // same-bank read only waits for the in-flight request
`endif

  always #5 clk = ~clk;

  banked_dmem_resp #(
    .LATENCY(2),
    .BANK_RECOVERY(4),
    .AW(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .wr(wr),
    .addr(addr),
    .data_in(data_in),
    .data_out(data_out),
    .done(done),
    .stall(stall),
    .err(err)
  );

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%04h", tag, obs);
    end
  endtask

  // Inputs change 2 ns after the rising edge. Outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
    enable  = en;
    wr      = w;
    addr    = a;
    data_in = d;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      tick();
    end
  endtask

  // Commits a write and waits long enough for the response and the bank
  // recovery to finish.
  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    drive(1'b1, 1'b1, a, d);
    check_eq("preload_stall", {15'b0, stall}, 16'h0000);
    tick();
    idle(6);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b0, 16'h0010, 16'h0000);
    tick();
    // reset state
    check_eq("rst_stall", {15'b0, stall}, 16'h0001);
    tick();
    check_eq("rst_done", {15'b0, done}, 16'h0000);
    check_eq("rst_err", {15'b0, err}, 16'h0000);
    check_eq("rst_dout", data_out, 16'h0000);
    rst = 1'b0;
    idle(2);

    preload(16'h0018, 16'h5A5A);
    preload(16'h0012, 16'h3C3C);

    // 1: write followed by a read-back
    drive(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    check_eq("t1_wr_stall", {15'b0, stall}, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    check_eq("t1_done_early", {15'b0, done}, 16'h0000);
    tick();
    check_eq("t1_wr_done", {15'b0, done}, 16'h0001);
    check_eq("t1_wr_dout", data_out, 16'h0000);
    check_eq("t1_wr_err", {15'b0, err}, 16'h0000);
    tick();
    tick();
    drive(1'b1, 1'b0, 16'h0010, 16'h0000);
    check_eq("t1_rd_stall", {15'b0, stall}, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    check_eq("t1_rd_done_early", {15'b0, done}, 16'h0000);
    check_eq("t1_rd_dout_early", data_out, 16'h0000);
    tick();
    check_eq("t1_rd_done", {15'b0, done}, 16'h0001);
    check_eq("t1_rd_dout", data_out, 16'hBEEF);
    tick();
    check_eq("t1_done_clear", {15'b0, done}, 16'h0000);
    idle(6);

    // 2: same-bank conflict. The read of 0x0018 is held from T=1.
    drive(1'b1, 1'b1, 16'h0010, 16'h1111);
    check_eq("t2_wr_stall", {15'b0, stall}, 16'h0000);
    tick();
    for (int t = 1; t <= ACC2 + 2; t++) begin
      if (t <= ACC2) drive(1'b1, 1'b0, 16'h0018, 16'(t));
      else           drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      if (t <= ACC2)
        check_eq($sformatf("t2_stall_T%0d", t), {15'b0, stall}, {15'b0, (t < ACC2)});
      check_eq($sformatf("t2_done_T%0d", t), {15'b0, done}, {15'b0, (t == 2 || t == ACC2 + 2)});
      check_eq($sformatf("t2_dout_T%0d", t), data_out, (t == ACC2 + 2) ? 16'h5A5A : 16'h0000);
      tick();
    end
    idle(6);

    // 3: different bank. The read of 0x0012 is accepted in the RESP cycle.
    drive(1'b1, 1'b1, 16'h0010, 16'h2222);
    tick();
    for (int t = 1; t <= 4; t++) begin
      if (t <= 2) drive(1'b1, 1'b0, 16'h0012, 16'h0000);
      else        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      if (t <= 2)
        check_eq($sformatf("t3_stall_T%0d", t), {15'b0, stall}, {15'b0, (t == 1)});
      check_eq($sformatf("t3_done_T%0d", t), {15'b0, done}, {15'b0, (t == 2 || t == 4)});
      check_eq($sformatf("t3_dout_T%0d", t), data_out, (t == 4) ? 16'h3C3C : 16'h0000);
      tick();
    end
    idle(6);

    // 4: misaligned write. A bank-0 read is accepted in its RESP cycle.
    drive(1'b1, 1'b1, 16'h0011, 16'h1234);
    check_eq("t4_mis_stall", {15'b0, stall}, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    check_eq("t4_done_early", {15'b0, done}, 16'h0000);
    tick();
    drive(1'b1, 1'b0, 16'h0010, 16'h0000);
    check_eq("t4_mis_done", {15'b0, done}, 16'h0001);
    check_eq("t4_mis_err", {15'b0, err}, 16'h0001);
    check_eq("t4_mis_dout", data_out, 16'h0000);
    check_eq("t4_rd_stall", {15'b0, stall}, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    check_eq("t4_err_clear", {15'b0, err}, 16'h0000);
    tick();
    check_eq("t4_rd_done", {15'b0, done}, 16'h0001);
    check_eq("t4_rd_err", {15'b0, err}, 16'h0000);
    check_eq("t4_rd_dout", data_out, 16'h2222);
    tick();
    idle(6);

    // 5: reset while a read is in flight
    drive(1'b1, 1'b0, 16'h0012, 16'h0000);
    check_eq("t5_rd_stall", {15'b0, stall}, 16'h0000);
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b1, 16'h0014, 16'h7777);
    check_eq("t5_done_dropped", {15'b0, done}, 16'h0000);
    check_eq("t5_err", {15'b0, err}, 16'h0000);
    check_eq("t5_dout", data_out, 16'h0000);
    check_eq("t5_new_stall", {15'b0, stall}, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    check_eq("t5_done_T3", {15'b0, done}, 16'h0000);
    tick();
    check_eq("t5_wr_done", {15'b0, done}, 16'h0001);
    tick();
    idle(6);
    drive(1'b1, 1'b0, 16'h0014, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    check_eq("t5_rb_done", {15'b0, done}, 16'h0001);
    check_eq("t5_rb_dout", data_out, 16'h7777);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
